lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter M, default 16, meaning memory word-address width (2^M 32-bit words); data width is fixed at 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, access request valid.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_size, input, 2, 0=byte, 1=half, 2=word, 3=illegal.
REQ-008 SHALL have port req_signed, input, 1, sign-extend load result.
REQ-009 SHALL have port req_addr, input, M+2, byte address.
REQ-010 SHALL have port req_wdata, input, 32, store data in low bits.
REQ-011 SHALL have port rsp_valid, output, 1, response valid.
REQ-012 SHALL have port rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
REQ-013 SHALL have port rsp_rdata, output, 32, load result; 0 for stores and errors.
REQ-014 SHALL have port rsp_err, output, 1, access rejected, no memory side effect.
REQ-015 SHALL have ports mem_address (output, M), mem_wf (output, 1), mem_w (output, 32), mem_v (input, 32), driving a word memory with combinational read and posedge write.

Function
REQ-016 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready=1 only in IDLE.
REQ-017 SHALL latch all req_* fields on acceptance; mem_address = latched req_addr[M+1:2] in every state.
REQ-018 SHALL route on acceptance: illegal size or error -> RESP; load -> READ; word store -> WRITE; byte/half store -> READ.
REQ-019 SHALL in READ capture mem_v into a word register, then go to RESP (load) or WRITE (sub-word store).
REQ-020 SHALL in WRITE assert mem_wf=1 for exactly one cycle with mem_w = merged word, then go to RESP; mem_wf=0 in all other states.
REQ-021 SHALL merge little-endian: byte lane addr[1:0], half lane addr[1]; unaddressed bytes keep the READ-captured value.
REQ-022 SHALL extract load data from the captured word by the same lanes, zero- or sign-extended per req_signed; word loads return the word unchanged.
REQ-023 SHALL hold rsp_valid=1 and rsp_rdata/rsp_err stable in RESP until rsp_ready, then return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-024 SHALL give latency acceptance-to-rsp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.

Reset
REQ-025 SHALL on rst_n=0 immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wf=0, mem_w=0, mem_address=0.
REQ-026 SHALL abort any in-flight access on reset; a store reset before its WRITE cycle leaves memory unmodified.

Configuration
REQ-027 SHALL with LSU_MISALIGN_TRAP_EN defined flag half with addr[0]=1 or word with addr[1:0]!=0 as error (rsp_err=1, no memory access).
REQ-028 SHALL without LSU_MISALIGN_TRAP_EN ignore misaligned low bits (half uses addr[1], word uses lane 0), never flagging misalignment.

Structure
REQ-029 SHALL place size encodings and the FSM state enum in shared package lsu_pkg.
REQ-030 SHALL put lane extract/merge in combinational sub-module lsu_lane.

Verification
REQ-031 SHALL cover: mem[0x10]=0x8899AABB, load byte signed addr 0x41 -> rsp_rdata 0xFFFFFFAA at acceptance+2.
REQ-032 SHALL cover: mem[0x10]=0x11223344, store half 0xBEEF addr 0x42 -> mem[0x10]=0xBEEF3344, one mem_wf pulse, rsp_valid at +3.
REQ-033 SHALL cover: word store 0xDEADBEEF addr 0x8 -> mem[2]=0xDEADBEEF, no READ state, rsp_rdata 0.
REQ-034 SHALL cover: req_size=3 -> rsp_err=1 at +1, mem_wf never asserted; word load addr 0x43 -> err with macro, mem[0x10] without.
REQ-035 SHALL cover: rsp_ready low 5 cycles -> rsp_valid and data held, req_ready=0 throughout.
REQ-036 SHALL cover: rst_n low during READ of a byte store -> memory unchanged, outputs at reset values same cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types for the load/store unit.
//   size_e    - access size encoding carried on req_size
//   state_e   - lsu_ctrl FSM states
//   req_t     - latched request payload (address kept separately, its width is parameterised)
//   is_misaligned() - alignment test used when LSU_MISALIGN_TRAP_EN is defined
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    size_e             size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Half needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational little-endian lane logic.
//   word     - memory word (read data)
//   wdata    - store data, valid in the low bits
//   size     - access size
//   lane     - byte address low bits (byte lane = lane, half lane = lane[1])
//   sgn      - sign-extend the extracted load value
//   merged_c - word with the addressed lanes replaced by wdata
//   rdata_c  - extracted, zero/sign-extended load value
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  size_e             size,
  input  logic [1:0]        lane,
  input  logic              sgn,
  output logic [DATA_W-1:0] merged_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? word[31:16] : word[15:0];

  // Extract and merge by size; word accesses always use lane 0.
  always_comb begin
    merged_c = word;
    rdata_c  = '0;
    case (size)
      SIZE_BYTE: begin
        rdata_c                      = {{24{sgn & byte_sel[7]}}, byte_sel};
        merged_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        rdata_c                           = {{16{sgn & half_sel[15]}}, half_sel};
        merged_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SIZE_WORD: begin
        rdata_c  = word;
        merged_c = wdata;
      end
      default: begin
        rdata_c  = '0;
        merged_c = word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of a 32-bit word memory
// (combinational read, posedge write). Sub-word stores are read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned half/word accesses with rsp_err.
// Ports:
//   clk, rst_n                  - clock, async active-low reset
//   req_valid/req_ready         - request handshake; ready only in IDLE
//   req_we, req_size, req_signed, req_addr, req_wdata - request fields
//   rsp_valid/rsp_ready         - response handshake; held until consumed
//   rsp_rdata, rsp_err          - load result (0 for stores/errors), error flag
//   mem_address, mem_wf, mem_w, mem_v - word memory port
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned M = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [M+1:0]      req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [M-1:0]      mem_address,
  output logic              mem_wf,
  output logic [DATA_W-1:0] mem_w,
  input  logic [DATA_W-1:0] mem_v
);

  state_e            state_q, state_d;
  req_t              req_q;
  logic [M+1:0]      addr_q;
  logic              accept;
  logic              bad_req;
  logic [DATA_W-1:0] rdata_d, mem_w_d;
  logic              err_d;
  logic [DATA_W-1:0] merged_c, extract_c;
  size_e             in_size;

  assign in_size     = size_e'(req_size);
  assign mem_address = addr_q[M+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad_req = (in_size == SIZE_ILL) || is_misaligned(in_size, req_addr[1:0]);
`else
  assign bad_req = (in_size == SIZE_ILL);
`endif

  // Lane logic always sees the live memory word; it is consumed only in READ.
  lsu_lane u_lane (
    .word     (mem_v),
    .wdata    (req_q.wdata),
    .size     (req_q.size),
    .lane     (addr_q[1:0]),
    .sgn      (req_q.sgn),
    .merged_c (merged_c),
    .rdata_c  (extract_c)
  );

  // State register and registered outputs, all loaded from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_wf    <= 1'b0;
      mem_w     <= '0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      mem_wf    <= (state_d == WRITE);
      mem_w     <= mem_w_d;
      if (accept) begin
        req_q  <= '{we: req_we, size: in_size, sgn: req_signed, wdata: req_wdata};
        addr_q <= req_addr;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    mem_w_d = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (bad_req) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (req_we && (in_size == SIZE_WORD)) begin
            state_d = WRITE;
            mem_w_d = req_wdata;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (req_q.we) begin
          state_d = WRITE;
          mem_w_d = merged_c;
        end else begin
          state_d = RESP;
          rdata_d = extract_c;
        end
      end
      WRITE: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          rdata_d = rsp_rdata;
          err_d   = rsp_err;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed self-checking bench for lsu_ctrl with a small word memory model.
module tb_lsu_ctrl;

  localparam int unsigned M = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [M+1:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [M-1:0] mem_address;
  logic        mem_wf;
  logic [31:0] mem_w;
  logic [31:0] mem_v;

  logic [31:0] mem [0:(1<<M)-1];
  logic        tb_wr = 1'b0;
  logic [M-1:0] tb_wr_addr = '0;
  logic [31:0] tb_wr_data = '0;
  int          wf_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.M(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_wf      (mem_wf),
    .mem_w       (mem_w),
    .mem_v       (mem_v)
  );

  // Word memory: combinational read, posedge write; bench preload shares the port.
  assign mem_v = mem[mem_address];
  always @(posedge clk) begin
    if (mem_wf) begin
      mem[mem_address] <= mem_w;
      wf_cnt <= wf_cnt + 1;
    end else if (tb_wr) begin
      mem[tb_wr_addr] <= tb_wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [M-1:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_wr = 1'b1; tb_wr_addr = a; tb_wr_data = d;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  // Issue one request and wait (bounded) for rsp_valid; leaves the response pending.
  task automatic issue(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                       input logic [M+1:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wf0;
    logic [31:0] held;

    // Reset values
    #2;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_wf", 32'(mem_wf), 32'd0);
    check("rst_w", mem_w, 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);

    // Loads from a known word
    preload(8'h10, 32'h8899AABB);
    issue("lb_s41", 1'b0, 2'd0, 1'b1, 10'h041, '0, 2, 32'hFFFFFFAA, 1'b0);
    finish_rsp("lb_s41");
    issue("lb_u43", 1'b0, 2'd0, 1'b0, 10'h043, '0, 2, 32'h00000088, 1'b0);
    finish_rsp("lb_u43");
    issue("lh_s42", 1'b0, 2'd1, 1'b1, 10'h042, '0, 2, 32'hFFFF8899, 1'b0);
    finish_rsp("lh_s42");
    issue("lh_u40", 1'b0, 2'd1, 1'b0, 10'h040, '0, 2, 32'h0000AABB, 1'b0);
    finish_rsp("lh_u40");
    issue("lw_40", 1'b0, 2'd2, 1'b1, 10'h040, '0, 2, 32'h8899AABB, 1'b0);
    finish_rsp("lw_40");
`ifdef LSU_MISALIGN_TRAP_EN
    issue("lw_43", 1'b0, 2'd2, 1'b0, 10'h043, '0, 1, 32'h0, 1'b1);
`else
    issue("lw_43", 1'b0, 2'd2, 1'b0, 10'h043, '0, 2, 32'h8899AABB, 1'b0);
`endif
    finish_rsp("lw_43");

    // Sub-word stores (read-modify-write)
    preload(8'h10, 32'h11223344);
    wf0 = wf_cnt;
    issue("sh_42", 1'b1, 2'd1, 1'b0, 10'h042, 32'h0000BEEF, 3, 32'h0, 1'b0);
    finish_rsp("sh_42");
    check("sh_42_mem", mem[16], 32'hBEEF3344);
    check("sh_42_wf", 32'(wf_cnt - wf0), 32'd1);
    wf0 = wf_cnt;
    issue("sb_41", 1'b1, 2'd0, 1'b0, 10'h041, 32'h12345655, 3, 32'h0, 1'b0);
    finish_rsp("sb_41");
    check("sb_41_mem", mem[16], 32'hBEEF5544);
    check("sb_41_wf", 32'(wf_cnt - wf0), 32'd1);

    // Word store skips READ
    wf0 = wf_cnt;
    issue("sw_08", 1'b1, 2'd2, 1'b0, 10'h008, 32'hDEADBEEF, 2, 32'h0, 1'b0);
    finish_rsp("sw_08");
    check("sw_08_mem", mem[2], 32'hDEADBEEF);
    check("sw_08_wf", 32'(wf_cnt - wf0), 32'd1);

    // Illegal size
    wf0 = wf_cnt;
    issue("ill", 1'b1, 2'd3, 1'b0, 10'h040, 32'h01020304, 1, 32'h0, 1'b1);
    finish_rsp("ill");
    check("ill_wf", 32'(wf_cnt - wf0), 32'd0);
    check("ill_mem", mem[16], 32'hBEEF5544);

    // Response backpressure
    rsp_ready = 1'b0;
    issue("bp", 1'b0, 2'd2, 1'b0, 10'h008, '0, 2, 32'hDEADBEEF, 1'b0);
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_ready", 32'(req_ready), 32'd0);
    end
    check("bp_first", held, 32'hDEADBEEF);
    finish_rsp("bp");

    // Reset while a byte store sits in READ
    preload(8'h20, 32'hCAFEF00D);
    wf0 = wf_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 10'h081; req_wdata = 32'h000000EE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rr_in_read_addr", 32'(mem_address), 32'h20);
    rst_n = 1'b0;
    #1;
    check("rr_valid", 32'(rsp_valid), 32'd0);
    check("rr_wf", 32'(mem_wf), 32'd0);
    check("rr_w", mem_w, 32'd0);
    check("rr_addr", 32'(mem_address), 32'd0);
    check("rr_rdata", rsp_rdata, 32'd0);
    check("rr_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rr_mem", mem[32], 32'hCAFEF00D);
    check("rr_nowf", 32'(wf_cnt - wf0), 32'd0);
    issue("rr_lw", 1'b0, 2'd2, 1'b0, 10'h080, '0, 2, 32'hCAFEF00D, 1'b0);
    finish_rsp("rr_lw");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
